// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: single-outstanding line read/write controller over an internal line array with fixed latency
module line_mem_ctrl #(
  parameter int LINE_WIDTH = 128,
  parameter int LINE_COUNT = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_i,
  input  logic                  Wen_i,
  input  logic [31:0]           Addr_i,
  input  logic [LINE_WIDTH-1:0] WriteD_i,
  output logic                  Ready_o,
  output logic                  RespValid_o,
  output logic [LINE_WIDTH-1:0] ReadD_o
);
  localparam int IW = $clog2(LINE_COUNT);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d, rd_q, rd_d;
  logic [LINE_WIDTH-1:0] mem [LINE_COUNT];
  logic                  unused_addr;
  assign unused_addr = ^{Addr_i[31:IW+4], Addr_i[3:0]};
  assign Ready_o     = state_q == IDLE && !rst;
  assign RespValid_o = state_q == RESP && !rst;
  assign ReadD_o     = rd_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && Valid_i) begin
      wen_d   = Wen_i;
      idx_d   = Addr_i[IW+3:4];
      wdata_d = WriteD_i;
      cnt_d   = CW'(LATENCY - 1);
      state_d = LATENCY == 1 ? RESP : BUSY;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_d == '0 ? RESP : BUSY;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    // Read data is captured on the edge that enters RESP, using the index being latched on that edge.
    rd_d = (state_d == RESP && state_q != RESP && !wen_d) ? mem[idx_d] : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wen_q) mem[idx_q] <= wdata_q;
  end
endmodule
